// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//   Decode-to-execute issue stage sitting in front of the register file.
//   - Drives register-file read addresses straight from decode and captures
//     the returned operands, bypassing same-cycle writeback data (the
//     register file only commits that data at the clock edge).
//   - Keeps a per-register busy scoreboard that blocks RAW/WAW hazards.
//   - Holds one registered issue bundle for execute, plus a saturating
//     count of stalled decode cycles.
//
// Handshakes (both sides): a transfer happens on a rising edge where
//   valid && ready. A producer holding valid keeps its payload stable
//   until the transfer; ready may depend combinationally on valid.
//   Decode side:  id_valid_i / id_ready_o  (id_ready_o is combinational).
//   Execute side: ex_valid_o / ex_ready_i  (ex_* are registered).
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   id_*                         instruction from decode
//   rf_rs1_o/rf_rs2_o            register-file read addresses
//   rf_rs1_data_i/rf_rs2_data_i  register-file read data (combinational)
//   wb_valid_i/wb_rd_i/wb_data_i writeback port (same cycle as RF write)
//   flush_i                      kill the bundle held in the issue register
//   ex_*                         issue bundle to execute
//   busy_o                       scoreboard vector, bit 0 always 0
//   stall_cnt_o                  saturating count of stalled cycles
// ---------------------------------------------------------------------------
module operand_fetch #(
    parameter int WIDTH = 32,
    parameter int UOPW  = 8,
    parameter int CNTW  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    output logic             id_ready_o,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_wen_i,
    input  logic [WIDTH-1:0] id_pc_i,
    input  logic [UOPW-1:0]  id_uop_i,
    output logic [4:0]       rf_rs1_o,
    output logic [4:0]       rf_rs2_o,
    input  logic [WIDTH-1:0] rf_rs1_data_i,
    input  logic [WIDTH-1:0] rf_rs2_data_i,
    input  logic             wb_valid_i,
    input  logic [4:0]       wb_rd_i,
    input  logic [WIDTH-1:0] wb_data_i,
    input  logic             flush_i,
    output logic             ex_valid_o,
    input  logic             ex_ready_i,
    output logic [WIDTH-1:0] ex_rs1_data_o,
    output logic [WIDTH-1:0] ex_rs2_data_o,
    output logic [4:0]       ex_rd_o,
    output logic             ex_wen_o,
    output logic [WIDTH-1:0] ex_pc_o,
    output logic [UOPW-1:0]  ex_uop_o,
    output logic [31:0]      busy_o,
    output logic [CNTW-1:0]  stall_cnt_o
);

    localparam logic [CNTW-1:0] STALL_MAX = '1;
    localparam logic [CNTW-1:0] STALL_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    logic [31:0]      busy_q;
    logic [31:0]      busy_d;
    logic [31:0]      clr;
    logic [31:0]      pending;
    logic             hazard;
    logic             accept;
    logic             handoff;
    logic             kill;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;

    // x0 reads as zero; a same-cycle writeback wins over the stale RF value.
    function automatic logic [WIDTH-1:0] select_operand(
        input logic [4:0]       idx,
        input logic [WIDTH-1:0] rf_data,
        input logic             wb_valid,
        input logic [4:0]       wb_rd,
        input logic [WIDTH-1:0] wb_data
    );
        if (idx == 5'd0)
            return '0;
        else if (wb_valid && wb_rd == idx)
            return wb_data;
        else
            return rf_data;
    endfunction

    assign rf_rs1_o = id_rs1_i;
    assign rf_rs2_o = id_rs2_i;
    assign busy_o   = busy_q;

    always_comb begin
        clr = '0;
        if (wb_valid_i && wb_rd_i != 5'd0)
            clr[wb_rd_i] = 1'b1;
    end

    // A register being written back this cycle no longer blocks issue.
    assign pending = busy_q & ~clr;

    assign hazard = id_valid_i &&
                    (pending[id_rs1_i] || pending[id_rs2_i] ||
                     (id_wen_i && pending[id_rd_i]));

    assign id_ready_o = !hazard && !flush_i && (!ex_valid_o || ex_ready_i);
    assign accept     = id_valid_i && id_ready_o;
    assign handoff    = ex_valid_o && ex_ready_i;

    // A flushed bundle that never reached execute will never write back,
    // so its destination reservation must be released here.
    assign kill = flush_i && ex_valid_o && !handoff && ex_wen_o && ex_rd_o != 5'd0;

    assign op1 = select_operand(id_rs1_i, rf_rs1_data_i, wb_valid_i, wb_rd_i, wb_data_i);
    assign op2 = select_operand(id_rs2_i, rf_rs2_data_i, wb_valid_i, wb_rd_i, wb_data_i);

    // Lowest priority first so later assignments win: wb clear, flush kill,
    // accept set.
    always_comb begin
        busy_d = busy_q & ~clr;
        if (kill)
            busy_d[ex_rd_o] = 1'b0;
        if (accept && id_wen_i && id_rd_i != 5'd0)
            busy_d[id_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q        <= '0;
            stall_cnt_o   <= '0;
            ex_valid_o    <= 1'b0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_rd_o       <= '0;
            ex_wen_o      <= 1'b0;
            ex_pc_o       <= '0;
            ex_uop_o      <= '0;
        end else begin
            busy_q <= busy_d;

            if (id_valid_i && !id_ready_o && stall_cnt_o != STALL_MAX)
                stall_cnt_o <= stall_cnt_o + STALL_ONE;

            if (flush_i) begin
                ex_valid_o <= 1'b0;
            end else if (accept) begin
                ex_valid_o    <= 1'b1;
                ex_rs1_data_o <= op1;
                ex_rs2_data_o <= op2;
                ex_rd_o       <= id_rd_i;
                ex_wen_o      <= id_wen_i;
                ex_pc_o       <= id_pc_i;
                ex_uop_o      <= id_uop_i;
            end else if (handoff) begin
                ex_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
Decode-to-execute issue stage that sits directly upstream of the register file.
- Drives the register-file read addresses and captures the returned operands.
- Bypasses same-cycle writeback data, which the register file only commits at the clock edge.
- Blocks RAW/WAW hazards with a per-register busy scoreboard.
- Presents a registered issue bundle to execute over a valid/ready handshake, with a saturating stall counter for performance debug.

Parameters:
WIDTH, 32, data/PC width; matches cpu_pkg::WIDTH
UOPW, 8, width of opaque micro-op field passed through to execute
CNTW, 16, stall counter width

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  asynchronous, active-high reset
id_valid_i  in  1  decode presents an instruction
id_ready_o  out  1  stage accepts the instruction this cycle
id_rs1_i  in  5  source 1 register index
id_rs2_i  in  5  source 2 register index
id_rd_i  in  5  destination register index
id_wen_i  in  1  instruction writes rd
id_pc_i  in  WIDTH  instruction PC
id_uop_i  in  UOPW  opaque control, passed through
rf_rs1_o  out  5  register-file read address 1 (combinational = id_rs1_i)
rf_rs2_o  out  5  register-file read address 2 (combinational = id_rs2_i)
rf_rs1_data_i  in  WIDTH  register-file read data 1 (combinational)
rf_rs2_data_i  in  WIDTH  register-file read data 2 (combinational)
wb_valid_i  in  1  writeback commits this cycle (same signals drive the register file write port)
wb_rd_i  in  5  writeback destination
wb_data_i  in  WIDTH  writeback data
flush_i  in  1  kill the instruction held in the issue register
ex_valid_o  out  1  issue bundle valid
ex_ready_i  in  1  execute accepts the bundle
ex_rs1_data_o  out  WIDTH  operand 1
ex_rs2_data_o  out  WIDTH  operand 2
ex_rd_o  out  5  destination
ex_wen_o  out  1  writes rd
ex_pc_o  out  WIDTH  PC
ex_uop_o  out  UOPW  micro-op
busy_o  out  32  scoreboard vector; bit 0 always 0
stall_cnt_o  out  CNTW  saturating count of stalled cycles

Behaviour:
- Reset (async, rst_i=1): ex_valid_o=0, all ex_* data/ctrl=0, busy=0, stall_cnt_o=0. id_ready_o may be combinationally 1 during reset; the bench does not drive id_valid_i while rst_i=1.
- Operand select, per source s:
  - index 0 -> 0;
  - else if wb_valid_i && wb_rd_i==s -> wb_data_i (bypass);
  - else -> rf data.
- wb_rd_i=0 never bypasses and never clears anything.
- clr[r] = wb_valid_i && wb_rd_i==r && r!=0.
- hazard = id_valid_i && ((busy[rs1] && !clr[rs1]) || (busy[rs2] && !clr[rs2]) || (id_wen_i && busy[rd] && !clr[rd])). Index 0 is never busy.
- id_ready_o = !hazard && !flush_i && (!ex_valid_o || ex_ready_i). It is combinational.
- accept = id_valid_i && id_ready_o. On accept:
  - the issue register loads operands and fields; ex_valid_o=1 next cycle (latency 1);
  - if id_wen_i && rd!=0, busy[rd] is set.
- Handoff = ex_valid_o && ex_ready_i with no accept the same cycle: ex_valid_o -> 0.
- Accept and handoff in the same cycle: the register reloads and ex_valid_o stays 1 (full throughput).
- While ex_valid_o && !ex_ready_i, all ex_* hold stable.
- Busy update priority per bit, highest first:
  1. set by accept;
  2. set-bit kill by flush;
  3. clear by writeback.
  A same-cycle accept-set and wb-clear of one register leaves it busy.
- flush_i=1:
  - ex_valid_o -> 0 next cycle;
  - if the held bundle had ex_wen_o && ex_rd_o!=0 and was not handed off this cycle, busy[ex_rd_o] is cleared;
  - no accept that cycle;
  - instructions already past this stage are unaffected and still write back.
- stall_cnt_o increments when id_valid_i && !id_ready_o and saturates at all-ones.
- Writeback to a non-busy register is legal: the register file is updated, the scoreboard is unchanged.

Test Plan:
1. Reset, then issue rs1=1, rs2=2, rd=3, wen=1, with regfile x1=0x11111111 and x2=0x22222222 -> next cycle ex_valid_o=1, operands 0x11111111/0x22222222, busy_o=0x00000008.
2. With busy[3] set, present rs1=3 for 3 cycles, then wb_valid_i, rd=3, data=0x33333333 -> id_ready_o=0 for 3 cycles, accept on the wb cycle, ex_rs1_data_o=0x33333333, stall_cnt_o=3, busy[3] cleared.
3. rs1=0, rs2=0 with wb_rd_i=0, data=0xFFFFFFFF -> both operands 0, no stall, busy unchanged.
4. Hold ex_ready_i=0 for 2 cycles with a second instruction waiting -> ex_* stable, id_ready_o=0. Raise ex_ready_i -> back-to-back accept, valid stays 1.
5. Issue rd=5, wen=1, then assert flush_i before ex_ready_i -> ex_valid_o=0, busy[5]=0, no accept in the flush cycle.
6. Assert rst_i asynchronously mid-stall with busy=0x000000F0 -> ex_valid_o=0, busy_o=0, stall_cnt_o=0 immediately without a clock edge.
